// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte stream, writes little-endian words
// into instruction memory from address 0, then checks the checksum and releases the core.
module imem_boot_loader #(
   parameter int SIZE       = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  rx_valid,
   input  logic [7:0]            rx_data,
   output logic                  rx_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_waddr,
   output logic [SIZE-1:0]       imem_wdata,
   output logic                  core_reset_n,
   output logic                  load_done,
   output logic                  load_error
);

   typedef enum logic [2:0] {HDR_LO, HDR_HI, PAYLOAD, CHECK, RUN, ERROR} state_t;

   localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

   state_t state, next_state;

   logic [7:0]          len_lo;
   logic [16:0]         word_total;
   logic [ADDR_WIDTH:0] word_cnt;
   logic [1:0]          byte_idx;
   logic [7:0]          sum;
   logic [23:0]         asm_word;

   logic        fire;
   logic [15:0] len_in;
   logic        len_bad;
   logic        word_last;
   logic        run_d;
   logic        err_d;

   assign fire      = rx_valid && rx_ready;
   assign len_in    = {rx_data, len_lo};
   assign len_bad   = (len_in == 16'd0) || ({1'b0, len_in} > MAX_WORDS);
   assign word_last = (byte_idx == 2'd3) && ((17'(word_cnt) + 17'd1) == word_total);

   always_ff @(posedge CLK) begin
      if (RESET) state <= HDR_LO;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         HDR_LO:  if (fire) next_state = HDR_HI;
         HDR_HI:  if (fire) next_state = len_bad ? ERROR : PAYLOAD;
         PAYLOAD: if (fire && word_last) next_state = CHECK;
         CHECK:   if (fire) next_state = (rx_data == sum) ? RUN : ERROR;
         default: next_state = state;
      endcase
   end

   // Status flags are registered from next_state so they rise at the deciding edge.
   always_comb begin
      rx_ready = !RESET && (state inside {HDR_LO, HDR_HI, PAYLOAD, CHECK});
      run_d    = (next_state == RUN);
      err_d    = (next_state == ERROR);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         len_lo       <= '0;
         word_total   <= '0;
         word_cnt     <= '0;
         byte_idx     <= '0;
         sum          <= '0;
         asm_word     <= '0;
         imem_we      <= 1'b0;
         imem_waddr   <= '0;
         imem_wdata   <= '0;
         core_reset_n <= 1'b0;
         load_done    <= 1'b0;
         load_error   <= 1'b0;
      end else begin
         imem_we      <= 1'b0;
         core_reset_n <= run_d;
         load_done    <= run_d;
         load_error   <= err_d;
         if (fire) begin
            case (state)
               HDR_LO: len_lo <= rx_data;
               HDR_HI: word_total <= {1'b0, len_in};
               PAYLOAD: begin
                  sum      <= sum + rx_data;
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: asm_word[7:0]   <= rx_data;
                     2'd1: asm_word[15:8]  <= rx_data;
                     2'd2: asm_word[23:16] <= rx_data;
                     default: begin
                        imem_we    <= 1'b1;
                        imem_waddr <= word_cnt[ADDR_WIDTH-1:0];
                        imem_wdata <= {rx_data, asm_word};
                        word_cnt   <= word_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
                     end
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: cycle table for the nominal image,
// plus randomized streams compared against a stream-level reference model.
module tb_imem_boot_loader;

   localparam int AW = 10;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          rx_valid;
   logic [7:0]    rx_data;
   logic          rx_ready;
   logic          imem_we;
   logic [AW-1:0] imem_waddr;
   logic [31:0]   imem_wdata;
   logic          core_reset_n;
   logic          load_done;
   logic          load_error;

   imem_boot_loader #(.SIZE(32), .ADDR_WIDTH(AW)) dut (
      .CLK(CLK), .RESET(RESET), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_ready(rx_ready), .imem_we(imem_we), .imem_waddr(imem_waddr),
      .imem_wdata(imem_wdata), .core_reset_n(core_reset_n),
      .load_done(load_done), .load_error(load_error)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } wr_t;

   typedef struct {
      logic [7:0]  data;
      bit          we;
      int          addr;
      logic [31:0] wdata;
      bit          done;
   } vec_t;

   int checks = 0;
   int fails  = 0;

   wr_t got[$];
   wr_t exp_q[$];
   bit  exp_done;
   bit  exp_err;

   always @(negedge CLK) begin
      if (imem_we) got.push_back('{addr: int'(imem_waddr), data: imem_wdata});
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // Reference model: interprets a byte stream directly from the format rules.
   task automatic runModel(input logic [7:0] s[$]);
      int n;
      int sum;
      int idx;
      exp_q.delete();
      exp_done = 0;
      exp_err  = 0;
      if (s.size() < 2) return;
      n = int'(s[0]) + 256 * int'(s[1]);
      if (n == 0 || n > (1 << AW)) begin
         exp_err = 1;
         return;
      end
      sum = 0;
      for (int w = 0; w < n; w++) begin
         if (2 + 4 * w + 3 >= s.size()) return;
         exp_q.push_back('{addr: w, data: {s[5 + 4*w], s[4 + 4*w], s[3 + 4*w], s[2 + 4*w]}});
         for (int b = 0; b < 4; b++) sum += int'(s[2 + 4*w + b]);
      end
      idx = 2 + 4 * n;
      if (idx < s.size()) begin
         if (int'(s[idx]) == (sum % 256)) exp_done = 1;
         else exp_err = 1;
      end
   endtask

   task automatic applyStimulus(input logic [7:0] s[$], input int max_gap);
      for (int i = 0; i < s.size(); i++) begin
         int gap;
         gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
         for (int g = 0; g < gap; g++) begin
            @(negedge CLK);
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
         end
         @(negedge CLK);
         rx_valid = 1'b1;
         rx_data  = s[i];
         @(posedge CLK);
      end
      @(negedge CLK);
      rx_valid = 1'b0;
   endtask

   task automatic doReset();
      @(negedge CLK);
      RESET    = 1'b1;
      rx_valid = 1'b1;
      rx_data  = 8'hFF;
      #1;
      checkOutput("rst_rx_ready", 32'(rx_ready), 32'd0);
      @(posedge CLK);
      #1;
      checkOutput("rst_we",      32'(imem_we),      32'd0);
      checkOutput("rst_waddr",   32'(imem_waddr),   32'd0);
      checkOutput("rst_wdata",   imem_wdata,        32'd0);
      checkOutput("rst_core",    32'(core_reset_n), 32'd0);
      checkOutput("rst_done",    32'(load_done),    32'd0);
      checkOutput("rst_error",   32'(load_error),   32'd0);
      @(negedge CLK);
      RESET    = 1'b0;
      rx_valid = 1'b0;
      got.delete();
   endtask

   task automatic checkImage(input string name);
      int bad;
      repeat (3) @(negedge CLK);
      checkOutput({name, "_nwrites"}, 32'(got.size()), 32'(exp_q.size()));
      bad = 0;
      if (got.size() == exp_q.size()) begin
         for (int i = 0; i < got.size(); i++)
            if (got[i].addr != exp_q[i].addr || got[i].data !== exp_q[i].data) bad++;
      end
      checkOutput({name, "_wrdata_errs"}, 32'(bad), 32'd0);
      checkOutput({name, "_done"},  32'(load_done),    32'(exp_done));
      checkOutput({name, "_core"},  32'(core_reset_n), 32'(exp_done));
      checkOutput({name, "_error"}, 32'(load_error),   32'(exp_err));
      checkOutput({name, "_ready"}, 32'(rx_ready),     32'(!(exp_done || exp_err)));
   endtask

   task automatic idleBytes(input string name, input bit done, input bit err);
      got.delete();
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         rx_valid = 1'b1;
         rx_data  = 8'($urandom);
      end
      @(negedge CLK);
      rx_valid = 1'b0;
      @(negedge CLK);
      checkOutput({name, "_idle_writes"}, 32'(got.size()), 32'd0);
      checkOutput({name, "_idle_done"},   32'(load_done),  32'(done));
      checkOutput({name, "_idle_error"},  32'(load_error), 32'(err));
      checkOutput({name, "_idle_core"},   32'(core_reset_n), 32'(done));
   endtask

   logic [7:0] nominal[$] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                              8'h13, 8'h01, 8'hA0, 8'h00, 8'h97};

   vec_t vec[11];

   initial begin
      logic [7:0] s[$];
      RESET    = 1'b1;
      rx_valid = 1'b0;
      rx_data  = 8'h00;

      // Per-cycle expectations for the nominal image with rx_valid held high.
      for (int i = 0; i < 11; i++) vec[i] = '{data: nominal[i], we: 0, addr: 0, wdata: 32'h0, done: 0};
      vec[5]  = '{data: 8'h00, we: 1, addr: 0, wdata: 32'h00500093, done: 0};
      vec[9]  = '{data: 8'h00, we: 1, addr: 1, wdata: 32'h00A00113, done: 0};
      vec[10] = '{data: 8'h97, we: 0, addr: 0, wdata: 32'h0, done: 1};

      repeat (2) @(posedge CLK);
      doReset();

      $display("[TB] nominal image, cycle table");
      for (int i = 0; i < 11; i++) begin
         @(negedge CLK);
         rx_valid = 1'b1;
         rx_data  = vec[i].data;
         @(posedge CLK);
         #1;
         checkOutput($sformatf("nom_we_%0d", i), 32'(imem_we), 32'(vec[i].we));
         if (vec[i].we) begin
            checkOutput($sformatf("nom_addr_%0d", i), 32'(imem_waddr), 32'(vec[i].addr));
            checkOutput($sformatf("nom_data_%0d", i), imem_wdata, vec[i].wdata);
         end
         checkOutput($sformatf("nom_done_%0d", i), 32'(load_done),    32'(vec[i].done));
         checkOutput($sformatf("nom_core_%0d", i), 32'(core_reset_n), 32'(vec[i].done));
      end
      @(negedge CLK);
      rx_valid = 1'b0;
      checkOutput("nom_ready_after", 32'(rx_ready), 32'd0);
      idleBytes("nom", 1'b1, 1'b0);

      $display("[TB] bad checksum");
      doReset();
      s = nominal;
      s[10] = 8'h98;
      runModel(s);
      applyStimulus(s, 0);
      checkImage("badchk");
      idleBytes("badchk", 1'b0, 1'b1);

      $display("[TB] length errors");
      doReset();
      s = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      runModel(s);
      applyStimulus(s, 0);
      checkImage("len0");
      doReset();
      s = '{8'h01, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      runModel(s);
      applyStimulus(s, 0);
      checkImage("len1025");

      $display("[TB] full-capacity image");
      doReset();
      begin
         int sum;
         sum = 0;
         s = '{8'h00, 8'h04};
         for (int i = 0; i < 4 * (1 << AW); i++) begin
            s.push_back(8'($urandom));
            sum += int'(s[s.size() - 1]);
         end
         s.push_back(8'(sum));
      end
      runModel(s);
      applyStimulus(s, 0);
      checkImage("len1024");
      checkOutput("len1024_last_addr", 32'(got.size() > 0 ? got[got.size() - 1].addr : -1), 32'd1023);

      $display("[TB] nominal with handshake gaps");
      doReset();
      runModel(nominal);
      applyStimulus(nominal, 5);
      checkImage("gaps");

      $display("[TB] reset mid-load");
      doReset();
      s = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01};
      applyStimulus(s, 0);
      repeat (2) @(negedge CLK);
      checkOutput("midrst_partial_writes", 32'(got.size()), 32'd1);
      doReset();
      runModel(nominal);
      applyStimulus(nominal, 2);
      checkImage("midrst");

      $display("[TB] randomized images");
      for (int t = 0; t < 8; t++) begin
         int n;
         int sum;
         doReset();
         n = int'($urandom_range(1, 8));
         s = '{8'(n), 8'h00};
         sum = 0;
         for (int i = 0; i < 4 * n; i++) begin
            s.push_back(8'($urandom));
            sum += int'(s[s.size() - 1]);
         end
         if ($urandom_range(0, 2) == 0) s.push_back(8'(sum + 1 + int'($urandom_range(0, 200))));
         else s.push_back(8'(sum));
         runModel(s);
         applyStimulus(s, 5);
         checkImage($sformatf("rand%0d", t));
      end

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
